// File: rtl/endian_deserializer.sv
// Serial-to-parallel word assembler with per-word selectable bit order and a held output slot.
// Optional feature: define PARITY_CHECK_EN to expect a trailing even-parity bit and report par_err.
module endian_deserializer #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         s_valid,
  input  logic         s_bit,
  input  logic         msb_first,
  output logic         w_valid,
  output logic [N-1:0] w_data,
  input  logic         w_ready,
  output logic         overrun,
  output logic         par_err
);

`ifdef PARITY_CHECK_EN
  localparam int L = N + 1;
`else
  localparam int L = N;
`endif
  localparam int CNT_W = $clog2(L + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(L - 1);

  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

  // Destination index of data bit k; returns out-of-range for the parity bit.
  function automatic int bit_pos(input logic [CNT_W-1:0] k, input logic msb);
    int kk;
    kk = int'(k);
    if (kk >= N) return -1;
    return msb ? (N - 1 - kk) : kk;
  endfunction

  logic [CNT_W-1:0] cnt_p0;
  logic [N-1:0]     sh_p0;
  logic             ord_p0;
  logic [N-1:0]     sh_nxt;
  logic             ord_eff;
  logic             accept;
  logic             first;
  logic             last;
  logic             complete;
  logic             can_load;
  logic             load;
  logic             consume;

  state_t           state_p1;
  state_t           state_nxt;
  logic [N-1:0]     data_p1;
  logic             ovr_p1;

  assign accept   = en & s_valid;
  assign first    = (cnt_p0 == '0);
  assign last     = (cnt_p0 == LAST);
  assign ord_eff  = first ? msb_first : ord_p0;
  assign complete = accept & last;
  assign consume  = w_valid & w_ready;
  assign can_load = ~w_valid | w_ready;
  assign load     = complete & can_load;

  always_comb begin
    int pos;
    sh_nxt = first ? '0 : sh_p0;
    pos    = bit_pos(cnt_p0, ord_eff);
    for (int i = 0; i < N; i++) begin
      if (i == pos) sh_nxt[i] = s_bit;
    end
  end

  // ---- stage 0: bit collection ----
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p0 <= '0;
      sh_p0  <= '0;
      ord_p0 <= 1'b0;
    end else if (!en) begin
      cnt_p0 <= '0;
      sh_p0  <= '0;
    end else if (s_valid) begin
      cnt_p0 <= last ? '0 : cnt_p0 + CNT_W'(1);
      sh_p0  <= sh_nxt;
      ord_p0 <= ord_eff;
    end
  end

`ifdef PARITY_CHECK_EN
  logic par_p0;
  logic par_nxt;
  logic perr_p1;

  assign par_nxt = first ? s_bit : (par_p0 ^ s_bit);

  always_ff @(posedge clk) begin
    if (rst) begin
      par_p0 <= 1'b0;
    end else if (!en) begin
      par_p0 <= 1'b0;
    end else if (s_valid) begin
      par_p0 <= par_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perr_p1 <= 1'b0;
    end else if (load) begin
      perr_p1 <= par_nxt;
    end else if (consume) begin
      perr_p1 <= 1'b0;
    end
  end

  assign par_err = perr_p1;
`else
  assign par_err = 1'b0;
`endif

  // ---- stage 1: output slot ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1 <= COLLECT;
    end else begin
      state_p1 <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_p1;
    case (state_p1)
      COLLECT: if (load) state_nxt = HOLD;
      HOLD:    if (w_ready && !load) state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  always_comb begin
    w_valid = (state_p1 == HOLD);
  end

  // Data is zeroed on consumption so w_data reads 0 whenever the slot is empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p1 <= '0;
      ovr_p1  <= 1'b0;
    end else begin
      ovr_p1 <= complete & ~can_load;
      if (load) begin
        data_p1 <= sh_nxt;
      end else if (consume) begin
        data_p1 <= '0;
      end
    end
  end

  assign w_data  = data_p1;
  assign overrun = ovr_p1;

endmodule

// File: tb/tb_endian_deserializer.sv
// Bench for endian_deserializer: directed scenarios then random traffic, every cycle compared
// against a queue-based reference model of the word-assembly rules.
module tb_endian_deserializer;
  localparam int N = 4;
`ifdef PARITY_CHECK_EN
  localparam int L = N + 1;
`else
  localparam int L = N;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_bit = 1'b0;
  logic         msb_first = 1'b0;
  logic         w_ready = 1'b0;
  logic         w_valid;
  logic [N-1:0] w_data;
  logic         overrun;
  logic         par_err;

  int checks = 0;
  int failures = 0;

  endian_deserializer #(.N(N)) dut (
    .clk(clk), .rst(rst), .en(en), .s_valid(s_valid), .s_bit(s_bit),
    .msb_first(msb_first), .w_valid(w_valid), .w_data(w_data),
    .w_ready(w_ready), .overrun(overrun), .par_err(par_err)
  );

  always #5 clk = ~clk;

  // Reference model state: bits of the word in progress, order of that word, output slot.
  bit           bq[$];
  logic         mord = 1'b0;
  logic         mv = 1'b0;
  logic [N-1:0] md = '0;
  logic         movr = 1'b0;
  logic         mperr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic x, input logic e, input logic sv, input logic b,
                       input logic m, input logic r);
    logic         consume;
    logic         do_load;
    logic [N-1:0] word;
    logic         perr;
    consume = mv && r;
    do_load = 1'b0;
    word    = '0;
    perr    = 1'b0;
    movr    = 1'b0;
    if (x) begin
      bq.delete();
      mord = 1'b0; mv = 1'b0; md = '0; mperr = 1'b0;
      return;
    end
    if (!e) begin
      bq.delete();
    end else if (sv) begin
      if (bq.size() == 0) mord = m;
      bq.push_back(b);
      if (bq.size() == L) begin
        for (int k = 0; k < N; k++) word[mord ? N - 1 - k : k] = bq[k];
`ifdef PARITY_CHECK_EN
        foreach (bq[k]) perr ^= bq[k];
`endif
        if (!mv || consume) do_load = 1'b1;
        else movr = 1'b1;
        bq.delete();
      end
    end
    if (do_load) begin
      mv = 1'b1; md = word; mperr = perr;
    end else if (consume) begin
      mv = 1'b0; md = '0; mperr = 1'b0;
    end
  endtask

  task automatic step(input logic x, input logic e, input logic sv, input logic b,
                      input logic m, input logic r);
    @(negedge clk);
    rst = x; en = e; s_valid = sv; s_bit = b; msb_first = m; w_ready = r;
    model(x, e, sv, b, m, r);
    @(posedge clk);
    #1;
    chk("w_valid", 32'(w_valid), 32'(mv));
    chk("w_data", 32'(w_data), 32'(md));
    chk("overrun", 32'(overrun), 32'(movr));
    chk("par_err", 32'(par_err), 32'(mperr));
  endtask

  // Sends one word (plus even parity when enabled); tog flips msb_first after bit 0.
  task automatic send_word(input logic [N-1:0] w, input logic m, input logic r, input logic tog);
    for (int k = 0; k < N; k++)
      step(1'b0, 1'b1, 1'b1, m ? w[N-1-k] : w[k], (k > 0 && tog) ? ~m : m, r);
`ifdef PARITY_CHECK_EN
    step(1'b0, 1'b1, 1'b1, ^w, m, r);
`endif
  endtask

  initial begin
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_valid", 32'(w_valid), 32'd0);
    chk("reset_data", 32'(w_data), 32'd0);

    // LSB-first 1,0,1,1 -> D
    send_word(4'hD, 1'b0, 1'b0, 1'b0);
    chk("lsb_word", 32'(w_data), 32'hD);
    chk("lsb_valid", 32'(w_valid), 32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("consumed", 32'(w_valid), 32'd0);

    // MSB-first 1,0,1,1 -> B, with and without mid-word order toggling
    send_word(4'hB, 1'b1, 1'b0, 1'b0);
    chk("msb_word", 32'(w_data), 32'hB);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    send_word(4'hB, 1'b1, 1'b0, 1'b1);
    chk("msb_toggle", 32'(w_data), 32'hB);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Overrun: two words without consumption
    send_word(4'h6, 1'b0, 1'b0, 1'b0);
    send_word(4'h9, 1'b0, 1'b0, 1'b0);
    chk("ovr_pulse", 32'(overrun), 32'd1);
    chk("ovr_keep", 32'(w_data), 32'h6);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovr_single", 32'(overrun), 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Partial word aborted by en=0
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    send_word(4'hE, 1'b0, 1'b0, 1'b0);
    chk("abort_word", 32'(w_data), 32'hE);

    // Back-to-back with w_ready high, then reset mid-word
    send_word(4'h1, 1'b0, 1'b1, 1'b0);
    chk("b2b_1", 32'(w_data), 32'h1);
    send_word(4'h2, 1'b0, 1'b1, 1'b0);
    chk("b2b_2", 32'(w_data), 32'h2);
    send_word(4'h3, 1'b0, 1'b1, 1'b0);
    chk("b2b_3", 32'(w_data), 32'h3);
    chk("b2b_novr", 32'(overrun), 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("rst_valid", 32'(w_valid), 32'd0);
    chk("rst_data", 32'(w_data), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);

`ifdef PARITY_CHECK_EN
    for (int k = 0; k < N; k++) step(1'b0, 1'b1, 1'b1, k < 2, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("par_ok_data", 32'(w_data), 32'h3);
    chk("par_ok", 32'(par_err), 32'd0);
    for (int k = 0; k < N; k++) step(1'b0, 1'b1, 1'b1, k < 2, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("par_bad", 32'(par_err), 32'd1);
`endif

    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 49) == 0, $urandom_range(0, 19) != 0,
           $urandom_range(0, 9) < 7, 1'($urandom), 1'($urandom),
           $urandom_range(0, 9) < 4);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
